vect_max_reduce: RTL and testbench
==================================

Name: vect_max_reduce

Overview:
- Row-maximum stage directly upstream of the vector function unit in the softmax datapath.
- Streams one softmax row in N-lane beats of fp16 and finds the single maximum element across every lane of every beat.
- Presents that maximum broadcast to all N lanes, ready to drive the vector unit's B operand for the subtract-then-exp step.
- Processes one row at a time, with a pipelined compare tree and a valid/ready handshake on both sides.

Parameters:
- N, 64, lanes per beat; must be a power of two and at least 2; LOGN = log2(N).
- CNT_W, 8, width of the row beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low.
- in_vect_flat  input  N*16  fp16 lanes; lane i occupies bits [16i+15:16i].
- in_tvalid  input  1  input beat valid.
- in_tlast  input  1  marks the final beat of the row.
- in_tready  output  1  the block can accept a beat.
- max_out_flat  output  N*16  row maximum replicated into every lane.
- max_scalar  output  16  row maximum.
- row_beats  output  CNT_W  beats in the reported row.
- out_tvalid  output  1  result valid.
- out_tready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst low at a clk edge) takes priority over everything, including a row in progress.
  - State returns to IDLE; all pipeline valids are cleared.
  - max_out_flat, max_scalar, row_beats and out_tvalid all go to 0; in_tready goes to 0 for that cycle.
  - No partial result is ever emitted after a reset.
- Ordering key, used only for comparison:
  - sign=1: key = ~x. sign=0: key = x ^ 16'h8000.
  - The larger unsigned key wins.
  - Consequences: +0 (0000) beats -0 (8000); -inf (FC00) is the minimum.
  - NaN is not supported; it is ordered by its key with no special handling.
  - Equal keys keep the lower-lane (or earlier) value.
- Tree:
  - LOGN levels of pairwise max, with a register after each level.
  - Each stage carries its own valid bit and last tag.
  - The tree is a pure feed-forward pipeline: a beat enters on acceptance (in_tvalid & in_tready) and never stalls.
- Accumulator, updated when a beat leaves the tree:
  - On the first beat of a row, the running max loads the tree output.
  - On later beats, the running max becomes max(running, tree output).
  - The beat counter increments per accepted beat and saturates at 2^CNT_W-1.
- FSM:
  - IDLE: in_tready=1. Accepting a beat moves to ACCUM, or to DRAIN if in_tlast=1.
  - ACCUM: in_tready=1. Accepting a beat with in_tlast=1 moves to DRAIN.
  - DRAIN: in_tready=0. When the last-tagged beat leaves the tree, the final max and count are registered, out_tvalid=1, and the state moves to OUT.
  - OUT: in_tready=0. Outputs are held stable while out_tvalid=1. When out_tready=1, out_tvalid clears on the next edge, the accumulator and counter clear, and the state moves to IDLE.
- Latency: with tlast accepted at edge T, out_tvalid rises at edge T+LOGN+1 (T+7 for N=64).
- Back-pressure: out_tready low in OUT holds everything indefinitely. in_tready returns high one cycle after the output handshake.
- Inputs in IDLE/ACCUM while in_tvalid=0 are ignored; gaps between beats are legal.
- A single-beat row (tlast on the first beat) is legal and reports row_beats=1.
- Data outputs keep their last value after the handshake, until the next result.

Optional Feature:
- Macro: VMR_LANE_MASK_EN.
- Defined:
  - Adds input in_lane_cnt, width LOGN+1, sampled with each accepted beat.
  - Lanes with index >= in_lane_cnt are replaced by -inf (FC00) before the tree.
  - in_lane_cnt=0 is treated as N.
  - Supports a short final beat.
- Undefined: port absent; all N lanes always participate.

Test Plan:
- Single beat, N=64: lane 17 = 4000 (2.0), all others 3C00 (1.0), tlast=1 -> max_scalar=4000, every lane of max_out_flat=4000, row_beats=1, out_tvalid exactly 7 cycles after acceptance.
- Sign and zero ordering: all lanes C000 (-2.0) except lane 0 = BC00 (-1.0) -> BC00. Separately, all lanes 8000 except one 0000 -> 0000.
- Three-beat row with in_tvalid gaps: beat maxima 3C00, 7BFF, 4000 -> 7BFF, row_beats=3; in_tready=0 from tlast acceptance until the handshake.
- Hold out_tready=0 for 10 cycles -> outputs stable, in_tready=0. Raise out_tready -> out_tvalid falls the next cycle, in_tready=1 the cycle after, and a second row's result is correct and independent of the first.
- Assert rst=0 mid-row after 2 beats -> all outputs 0 and state IDLE. A following row of all-3C00 beats reports 3C00 with the correct row_beats.
- With VMR_LANE_MASK_EN defined: in_lane_cnt=8, lanes 8..63 = 7BFF, lanes 0..7 = 3C00 -> 3C00.

Source files
------------

// File: rtl/vect_max_reduce.sv
// vect_max_reduce: streaming fp16 row-maximum for the softmax datapath.
// Each accepted beat of N lanes passes through a LOGN-level registered
// compare tree. The tree results are folded into a running maximum. At
// the end of the row that maximum is reported as a scalar and is also
// broadcast to every lane.
// Optional feature macro: VMR_LANE_MASK_EN adds in_lane_cnt. Lanes at or
// above in_lane_cnt are forced to -inf, and in_lane_cnt == 0 means all N
// lanes take part.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no row in progress, accepting the first beat of a row
// S_ACCUM | row in progress, accepting further beats
// S_DRAIN | last beat accepted, waiting for it to leave tree and accum
// S_OUT   | result presented, waiting for out_tready
module vect_max_reduce #(
  parameter  int N     = 64,
  parameter  int CNT_W = 8,
  localparam int LOGN  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*16-1:0]   in_vect_flat,
  input  logic              in_tvalid,
  input  logic              in_tlast,
`ifdef VMR_LANE_MASK_EN
  input  logic [LOGN:0]     in_lane_cnt,
`endif
  output logic              in_tready,
  output logic [N*16-1:0]   max_out_flat,
  output logic [15:0]       max_scalar,
  output logic [CNT_W-1:0]  row_beats,
  output logic              out_tvalid,
  input  logic              out_tready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

  // Map fp16 onto an unsigned key whose order matches numeric order.
  function automatic logic [15:0] ord_key(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  // The first argument is the lower lane or the earlier value, and it wins ties.
  function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
    return (ord_key(b) > ord_key(a)) ? b : a;
  endfunction

  state_t           state;
  logic [15:0]      node [2:2*N-1];
  logic [15:0]      tr_q [1:N-1];
  logic [LOGN-1:0]  vld_q;
  logic [LOGN-1:0]  lst_q;
  logic [15:0]      acc_q;
  logic             acc_have;
  logic             acc_done;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept       = in_tvalid & in_tready;
  assign max_out_flat = {N{max_scalar}};

  // The tree uses heap layout. Nodes N..2N-1 are the input lanes and nodes 2..N-1 are registered.
  always_comb begin
    for (int i = 2; i < N; i++) node[i] = tr_q[i];
    for (int j = 0; j < N; j++) begin
`ifdef VMR_LANE_MASK_EN
      node[N+j] = (in_lane_cnt == '0 || (LOGN+1)'(j) < in_lane_cnt)
                  ? in_vect_flat[16*j +: 16] : 16'hFC00;
`else
      node[N+j] = in_vect_flat[16*j +: 16];
`endif
    end
  end

  // The compare tree is feed-forward. Whether its data is valid is carried by vld_q and lst_q.
  always_ff @(posedge clk) begin
    for (int i = 1; i < N; i++) tr_q[i] <= fmax(node[2*i], node[2*i+1]);
  end

  // Row control: valid/last tags, accumulator, beat counter and FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      in_tready  <= 1'b0;
      out_tvalid <= 1'b0;
      max_scalar <= '0;
      row_beats  <= '0;
      vld_q      <= '0;
      lst_q      <= '0;
      acc_q      <= '0;
      acc_have   <= 1'b0;
      acc_done   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_q[0] <= accept;
      lst_q[0] <= accept & in_tlast;
      for (int k = 1; k < LOGN; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end

      if (accept && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

      if (vld_q[LOGN-1]) begin
        acc_q    <= acc_have ? fmax(acc_q, tr_q[1]) : tr_q[1];
        acc_have <= 1'b1;
        if (lst_q[LOGN-1]) acc_done <= 1'b1;
      end

      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            state     <= in_tlast ? S_DRAIN : S_ACCUM;
            in_tready <= ~in_tlast;
          end else begin
            in_tready <= 1'b1;
          end
        end
        S_DRAIN: begin
          in_tready <= 1'b0;
          if (acc_done) begin
            max_scalar <= acc_q;
            row_beats  <= cnt_q;
            out_tvalid <= 1'b1;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          in_tready <= 1'b0;
          if (out_tready) begin
            out_tvalid <= 1'b0;
            acc_have   <= 1'b0;
            acc_done   <= 1'b0;
            cnt_q      <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vect_max_reduce.sv
// tb_vect_max_reduce: scoreboard bench for vect_max_reduce (N=64, CNT_W=8).
module tb_vect_max_reduce;
  localparam int N     = 64;
  localparam int CNT_W = 8;
  localparam int LOGN  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N*16-1:0]   in_vect_flat = '0;
  logic              in_tvalid = 1'b0;
  logic              in_tlast = 1'b0;
  logic              in_tready;
  logic [N*16-1:0]   max_out_flat;
  logic [15:0]       max_scalar;
  logic [CNT_W-1:0]  row_beats;
  logic              out_tvalid;
  logic              out_tready = 1'b0;
`ifdef VMR_LANE_MASK_EN
  logic [LOGN:0]     in_lane_cnt = '0;
`endif

  vect_max_reduce #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vect_flat (in_vect_flat),
    .in_tvalid    (in_tvalid),
    .in_tlast     (in_tlast),
`ifdef VMR_LANE_MASK_EN
    .in_lane_cnt  (in_lane_cnt),
`endif
    .in_tready    (in_tready),
    .max_out_flat (max_out_flat),
    .max_scalar   (max_scalar),
    .row_beats    (row_beats),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]      mx;
    logic [CNT_W-1:0] beats;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          accept_cyc = 0;
  logic [15:0] run_max = '0;
  bit          run_have = 0;
  int          run_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  // Linear scan that keeps the first maximum. Lanes at or above 'lanes' count as -inf.
  function automatic logic [15:0] model_max(input logic [N*16-1:0] v, input int lanes);
    logic [15:0] best = 16'hFC00;
    logic [15:0] x;
    for (int j = 0; j < N; j++) begin
      x = (j < lanes) ? v[16*j +: 16] : 16'hFC00;
      if (j == 0 || key(x) > key(best)) best = x;
    end
    return best;
  endfunction

  function automatic logic [N*16-1:0] fill(input logic [15:0] x);
    return {N{x}};
  endfunction

  function automatic logic [N*16-1:0] rand_vec();
    logic [N*16-1:0] v;
    for (int j = 0; j < N; j++) v[16*j +: 16] = 16'($urandom);
    return v;
  endfunction

  // Presents one beat from a negedge and returns at the negedge after its acceptance.
  task automatic drive_beat(input logic [N*16-1:0] v, input bit last, input int gap, input int lanes);
    int w;
    logic [15:0] bm;
    repeat (gap) @(negedge clk);
    in_vect_flat = v;
    in_tlast     = last;
    in_tvalid    = 1'b1;
`ifdef VMR_LANE_MASK_EN
    in_lane_cnt  = (LOGN+1)'((lanes >= N) ? 0 : lanes);
`endif
    w = 0;
    while (!in_tready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("tready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    accept_cyc   = cyc;
    in_tvalid    = 1'b0;
    in_tlast     = 1'b1;
    in_vect_flat = fill(16'h7BFF);
    bm = model_max(v, lanes);
    if (!run_have || key(bm) > key(run_max)) run_max = bm;
    run_have = 1;
    if (run_cnt < 255) run_cnt++;
    if (last) begin
      sb_q.push_back('{mx: run_max, beats: CNT_W'(run_cnt)});
      run_have = 0;
      run_cnt  = 0;
      check("tready_after_last", 32'(in_tready), 32'd0);
    end
  endtask

  task automatic wait_result(input string tag, input int hold, input int exp_lat);
    int   w;
    int   nbad;
    bit   ok;
    bit   stable;
    exp_t e;
    w  = 0;
    ok = 1;
    while (!out_tvalid && w < 40) begin
      if (in_tready !== 1'b0) ok = 0;
      @(negedge clk);
      w++;
    end
    check({tag, "_tready_drain"}, 32'(ok), 32'd1);
    if (!out_tvalid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_lat > 0) check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(exp_lat));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_max"}, 32'(max_scalar), 32'(e.mx));
    check({tag, "_beats"}, 32'(row_beats), 32'(e.beats));
    nbad = 0;
    for (int j = 0; j < N; j++) if (max_out_flat[16*j +: 16] !== e.mx) nbad++;
    check({tag, "_lanes_bad"}, 32'(nbad), 32'd0);
    if (hold > 0) begin
      out_tready = 1'b0;
      stable = 1;
      repeat (hold) begin
        @(negedge clk);
        if (!out_tvalid || max_scalar !== e.mx || row_beats !== e.beats || in_tready) stable = 0;
      end
      check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    end
    out_tready = 1'b1;
    @(negedge clk);
    out_tready = 1'b0;
    check({tag, "_tvalid_fall"}, 32'(out_tvalid), 32'd0);
    check({tag, "_tready_low"}, 32'(in_tready), 32'd0);
    check({tag, "_data_kept"}, 32'(max_scalar), 32'(e.mx));
    @(negedge clk);
    check({tag, "_tready_back"}, 32'(in_tready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*16-1:0] v;
    bit              quiet;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_max", 32'(max_scalar), 32'd0);
    check("rst_beats", 32'(row_beats), 32'd0);
    check("rst_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_tready", 32'(in_tready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_tready", 32'(in_tready), 32'd1);

    // Single beat: the maximum is in lane 17.
    v = fill(16'h3C00);
    v[16*17 +: 16] = 16'h4000;
    drive_beat(v, 1, 0, N);
    wait_result("single", 0, LOGN + 1);

    // Negative values and signed-zero ordering.
    v = fill(16'hC000);
    v[15:0] = 16'hBC00;
    drive_beat(v, 1, 0, N);
    wait_result("neg", 0, LOGN + 1);
    v = fill(16'h8000);
    v[16*40 +: 16] = 16'h0000;
    drive_beat(v, 1, 0, N);
    wait_result("zero", 0, -1);

    // Three beats with gaps between them. The junk on the bus while valid is low must be ignored.
    v = fill(16'hBC00);
    v[16*5 +: 16] = 16'h3C00;
    drive_beat(v, 0, 0, N);
    v = fill(16'h3800);
    v[16*63 +: 16] = 16'h7BFF;
    drive_beat(v, 0, 3, N);
    v = fill(16'hC000);
    v[15:0] = 16'h4000;
    drive_beat(v, 1, 2, N);
    wait_result("three", 0, LOGN + 1);

    // Back-pressure for 10 cycles, then an independent second row.
    drive_beat(rand_vec(), 0, 0, N);
    drive_beat(rand_vec(), 1, 1, N);
    wait_result("hold", 10, -1);
    for (int b = 0; b < 4; b++) drive_beat(rand_vec(), b == 3, b % 2, N);
    wait_result("second", 0, -1);

    // Reset in the middle of a row.
    drive_beat(fill(16'h7BFF), 0, 0, N);
    drive_beat(fill(16'h7BFF), 0, 0, N);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_max", 32'(max_scalar), 32'd0);
    check("midrst_beats", 32'(row_beats), 32'd0);
    check("midrst_tvalid", 32'(out_tvalid), 32'd0);
    check("midrst_tready", 32'(in_tready), 32'd0);
    check("midrst_flat_nonzero", 32'(|max_out_flat), 32'd0);
    rst = 1'b1;
    run_have = 0;
    run_cnt  = 0;
    quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (out_tvalid) quiet = 0;
    end
    check("midrst_no_partial", 32'(quiet), 32'd1);
    check("midrst_idle_tready", 32'(in_tready), 32'd1);
    for (int b = 0; b < 3; b++) drive_beat(fill(16'h3C00), b == 2, 0, N);
    wait_result("after_rst", 0, LOGN + 1);

    // The beat counter saturates at 255.
    for (int b = 0; b < 260; b++) drive_beat(rand_vec(), b == 259, 0, N);
    wait_result("saturate", 0, LOGN + 1);

`ifdef VMR_LANE_MASK_EN
    v = fill(16'h7BFF);
    for (int j = 0; j < 8; j++) v[16*j +: 16] = 16'h3C00;
    drive_beat(v, 1, 0, 8);
    wait_result("mask", 0, LOGN + 1);
    drive_beat(fill(16'hC000), 0, 0, N);
    v = fill(16'h7BFF);
    v[16*2 +: 16] = 16'h4000;
    drive_beat(v, 1, 0, 3);
    wait_result("mask_short", 0, LOGN + 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
